hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage, 8-register, 32-bit core.
- Tracks destination registers of in-flight instructions in its own shadow EX/MEM/WB slots.
- Produces the registered forwarding selects consumed by the ALU forwarding mux, plus the pipeline hold/bubble/flush controls.
- Covers load-use stalls, data-memory wait states and taken-branch squashes.

---
 rtl/core_pkg.sv | 24 ++
 rtl/hazard_match.sv | 15 +
 rtl/hazard_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and encodings for the core's hazard logic: shadow pipeline slots,
// forwarding select codes and the data-memory wait FSM states.
package core_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             mr;
    logic             mw;
  } slot_t;

  typedef enum logic [0:0] {
    RUN,
    MEM_WAIT
  } state_e;

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator: does an in-flight slot produce the register an ID operand reads?
module hazard_match
  import core_pkg::*;
(
  input  logic             valid_i,
  input  logic             we_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] operand_i,
  input  logic             used_i,
  output logic             match_o
);

  assign match_o = valid_i & we_i & used_i & (rd_i == operand_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: shadow EX/MEM/WB slots, registered forwarding selects,
// load-use stalls, branch squash and data-memory wait handling with a sticky timeout flag.
module hazard_ctrl
  import core_pkg::slot_t, core_pkg::state_e, core_pkg::RUN, core_pkg::MEM_WAIT,
         core_pkg::FWD_REG, core_pkg::FWD_MEM, core_pkg::FWD_WB;
#(
  parameter int unsigned REG_W       = 3,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rqrd,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_uses_rqrd,
  input  logic             id_uses_rs,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_write_en,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             ex_branch_taken,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_rqrd_sel,
  output logic [1:0]       fwd_rs_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] TimeoutVal = WCNT_W'(MEM_TIMEOUT);

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_slot;
  state_e           state_q, state_d;
  logic [1:0]       fwd_rqrd_q, fwd_rqrd_d, fwd_rs_q, fwd_rs_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic ex_rqrd_m, ex_rs_m, mem_rqrd_m, mem_rs_m;
  logic mem_access, wait_active, load_use, squash;
  logic unused_wb;

  assign id_slot = '{valid: id_valid, rd: id_rd, we: id_write_en,
                     mr: id_mem_read, mw: id_mem_write};

  hazard_match u_match_ex_rqrd (
    .valid_i  (ex_q.valid),
    .we_i     (ex_q.we),
    .rd_i     (ex_q.rd),
    .operand_i(id_rqrd),
    .used_i   (id_uses_rqrd),
    .match_o  (ex_rqrd_m)
  );

  hazard_match u_match_ex_rs (
    .valid_i  (ex_q.valid),
    .we_i     (ex_q.we),
    .rd_i     (ex_q.rd),
    .operand_i(id_rs),
    .used_i   (id_uses_rs),
    .match_o  (ex_rs_m)
  );

  hazard_match u_match_mem_rqrd (
    .valid_i  (mem_q.valid),
    .we_i     (mem_q.we),
    .rd_i     (mem_q.rd),
    .operand_i(id_rqrd),
    .used_i   (id_uses_rqrd),
    .match_o  (mem_rqrd_m)
  );

  hazard_match u_match_mem_rs (
    .valid_i  (mem_q.valid),
    .we_i     (mem_q.we),
    .rd_i     (mem_q.rd),
    .operand_i(id_rs),
    .used_i   (id_uses_rs),
    .match_o  (mem_rs_m)
  );

  assign mem_access = mem_q.valid & (mem_q.mr | mem_q.mw);
  // MEM forwarding only carries the load address, so a load in EX or MEM both stall.
  assign load_use   = id_valid & (((ex_rqrd_m | ex_rs_m) & ex_q.mr) |
                                  ((mem_rqrd_m | mem_rs_m) & mem_q.mr));
  // Keeps every control output low while reset is held, even with a branch input high.
  assign squash     = ex_branch_taken & rst_n;
  assign unused_wb  = ^wb_q;

  // Wait FSM and pipeline controls; a MEM wait outranks squash, which outranks load-use.
  always_comb begin
    state_d      = state_q;
    wait_active  = 1'b0;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_access && !dmem_ready) begin
          wait_active = 1'b1;
          state_d     = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          wait_active = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (wait_active) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (squash) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = '0;
    fwd_rqrd_d = fwd_rqrd_q;
    fwd_rs_d   = fwd_rs_q;

    if (!wait_active) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = id_slot;
      if (idex_bubble) begin
        ex_d.valid = 1'b0;
        fwd_rqrd_d = FWD_REG;
        fwd_rs_d   = FWD_REG;
      end else begin
        fwd_rqrd_d = (id_valid && ex_rqrd_m)  ? FWD_MEM :
                     (id_valid && mem_rqrd_m) ? FWD_WB  : FWD_REG;
        fwd_rs_d   = (id_valid && ex_rs_m)    ? FWD_MEM :
                     (id_valid && mem_rs_m)   ? FWD_WB  : FWD_REG;
      end
    end
  end

  always_comb begin
    wcnt_d    = '0;
    timeout_d = timeout_q;
    if (wait_active) begin
      wcnt_d = (wcnt_q == TimeoutVal) ? wcnt_q : wcnt_q + 1'b1;
      if (MEM_TIMEOUT != 0 && wcnt_d == TimeoutVal) begin
        timeout_d = 1'b1;
      end
    end
    stall_d = (pc_hold && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      fwd_rqrd_q <= FWD_REG;
      fwd_rs_q   <= FWD_REG;
      wcnt_q     <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      fwd_rqrd_q <= fwd_rqrd_d;
      fwd_rs_q   <= fwd_rs_d;
      wcnt_q     <= wcnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  assign fwd_rqrd_sel = fwd_rqrd_q;
  assign fwd_rs_sel   = fwd_rs_q;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, MEM wait, timeout, squash, async reset.
module tb_hazard_ctrl;

  localparam int unsigned REG_W = 3;
  localparam int unsigned TO    = 4;
  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] CtlNone = 7'b0000000;
  localparam logic [6:0] CtlLu   = 7'b1100100;
  localparam logic [6:0] CtlSq   = 7'b0010100;
  localparam logic [6:0] CtlWait = 7'b1101011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_uses_rqrd, id_uses_rs, id_write_en, id_mem_read, id_mem_write;
  logic [REG_W-1:0] id_rqrd, id_rs, id_rd;
  logic             ex_branch_taken, dmem_ready;
  logic             pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble;
  logic             exmem_hold, memwb_bubble, mem_timeout;
  logic [1:0]       fwd_rqrd_sel, fwd_rs_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic [6:0]       ctl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble};

  hazard_ctrl #(
    .REG_W      (REG_W),
    .MEM_TIMEOUT(TO),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rqrd        (id_rqrd),
    .id_rs          (id_rs),
    .id_uses_rqrd   (id_uses_rqrd),
    .id_uses_rs     (id_uses_rs),
    .id_rd          (id_rd),
    .id_write_en    (id_write_en),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .ex_branch_taken(ex_branch_taken),
    .dmem_ready     (dmem_ready),
    .pc_hold        (pc_hold),
    .ifid_hold      (ifid_hold),
    .ifid_flush     (ifid_flush),
    .idex_hold      (idex_hold),
    .idex_bubble    (idex_bubble),
    .exmem_hold     (exmem_hold),
    .memwb_bubble   (memwb_bubble),
    .fwd_rqrd_sel   (fwd_rqrd_sel),
    .fwd_rs_sel     (fwd_rs_sel),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [2:0] rq, input logic urq,
                       input logic [2:0] rs, input logic urs, input logic [2:0] rd,
                       input logic we, input logic mr);
    id_valid     = v;
    id_rqrd      = rq;
    id_uses_rqrd = urq;
    id_rs        = rs;
    id_uses_rs   = urs;
    id_rd        = rd;
    id_write_en  = we;
    id_mem_read  = mr;
    id_mem_write = 1'b0;
  endtask

  task automatic nop();
    issue(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    ex_branch_taken = 1'b1;
    dmem_ready      = 1'b1;
    nop();
    #12;
    check_eq("reset_ctl", 32'(ctl), 32'(CtlNone));
    check_eq("reset_fwd", 32'({fwd_rqrd_sel, fwd_rs_sel}), 32'h0);
    check_eq("reset_timeout", 32'(mem_timeout), 32'h0);
    check_eq("reset_stall", stall_cycles, 32'h0);
    ex_branch_taken = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // ALU forwarding: ADD r3,r1,r2 ; SUB r4,r3,r1 ; OR r5,r1,r3
    issue(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
    #2 check_eq("fwd_add_ctl", 32'(ctl), 32'(CtlNone));
    tick();
    issue(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    #2 check_eq("fwd_sub_ctl", 32'(ctl), 32'(CtlNone));
    tick();
    check_eq("fwd_sub_rqrd", 32'(fwd_rqrd_sel), 32'h1);
    check_eq("fwd_sub_rs", 32'(fwd_rs_sel), 32'h0);
    issue(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0);
    tick();
    check_eq("fwd_or_rqrd", 32'(fwd_rqrd_sel), 32'h0);
    check_eq("fwd_or_rs", 32'(fwd_rs_sel), 32'h2);
    check_eq("fwd_stall", stall_cycles, 32'h0);
    drain();

    // Load-use: LOAD r2,(r0) ; ADD r5,r2,r2 -> two stall cycles
    issue(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    issue(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
    #2 check_eq("lu_c1_ctl", 32'(ctl), 32'(CtlLu));
    tick();
    #2 check_eq("lu_c2_ctl", 32'(ctl), 32'(CtlLu));
    tick();
    #2 check_eq("lu_c3_ctl", 32'(ctl), 32'(CtlNone));
    tick();
    check_eq("lu_fwd_rqrd", 32'(fwd_rqrd_sel), 32'h0);
    check_eq("lu_fwd_rs", 32'(fwd_rs_sel), 32'h0);
    check_eq("lu_stall", stall_cycles, 32'd2);
    drain();

    // MEM wait 3 cycles; a branch in the first wait cycle is deferred
    issue(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    nop();
    tick();
    issue(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1, 1'b0);
    dmem_ready      = 1'b0;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 check_eq($sformatf("wait_c%0d_ctl", i), 32'(ctl), 32'(CtlWait));
      tick();
      ex_branch_taken = 1'b0;
    end
    dmem_ready = 1'b1;
    #2 check_eq("wait_ready_ctl", 32'(ctl), 32'(CtlNone));
    tick();
    check_eq("wait_stall", stall_cycles, 32'd5);
    check_eq("wait_no_timeout", 32'(mem_timeout), 32'h0);
    drain();

    // Timeout: 6 wait cycles with MEM_TIMEOUT=4
    issue(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    nop();
    tick();
    dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq($sformatf("to_w%0d", i), 32'(mem_timeout), (i >= 4) ? 32'h1 : 32'h0);
    end
    dmem_ready = 1'b1;
    tick();
    drain();
    check_eq("to_sticky", 32'(mem_timeout), 32'h1);
    check_eq("to_stall", stall_cycles, 32'd11);

    // Branch squash wins over a load-use in the same cycle
    issue(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    issue(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    check_eq("sq_pre_fwd", 32'(fwd_rqrd_sel), 32'h1);
    issue(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #2 check_eq("sq_ctl", 32'(ctl), 32'(CtlSq));
    tick();
    ex_branch_taken = 1'b0;
    check_eq("sq_fwd", 32'(fwd_rqrd_sel), 32'h0);
    check_eq("sq_stall", stall_cycles, 32'd11);
    drain();

    // Async reset in the middle of a MEM wait
    issue(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    issue(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
    tick();
    issue(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1, 1'b0);
    tick();
    check_eq("rw_pre_fwd", 32'(fwd_rqrd_sel), 32'h2);
    nop();
    dmem_ready = 1'b0;
    #2 check_eq("rw_wait_ctl", 32'(ctl), 32'(CtlWait));
    tick();
    check_eq("rw_hold_fwd", 32'(fwd_rqrd_sel), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rw_rst_ctl", 32'(ctl), 32'(CtlNone));
    check_eq("rw_rst_fwd", 32'({fwd_rqrd_sel, fwd_rs_sel}), 32'h0);
    check_eq("rw_rst_timeout", 32'(mem_timeout), 32'h0);
    check_eq("rw_rst_stall", stall_cycles, 32'h0);
    dmem_ready = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    issue(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    issue(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    tick();
    check_eq("rw_post_rqrd", 32'(fwd_rqrd_sel), 32'h1);
    check_eq("rw_post_stall", stall_cycles, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
